// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: FSM state and the queued prediction record.
package bru_pkg;
  localparam int PC_W = 32;

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} bru_state_e;

  typedef struct packed {
    logic            taken;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] fallthru;
  } bru_entry_t;
endpackage

// File: rtl/bru_fifo.sv
// Generic synchronous FIFO with clear (clear beats push), full/empty flags and occupancy count.
module bru_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Checks EX branch outcomes against queued IF predictions; flushes and redirects on mismatch.
// Optional statistics counters are built when BRU_STATS_EN is defined.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int PC_W        = bru_pkg::PC_W,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic             pred_taken,
  input  logic [PC_W-1:0]  pred_target,
  input  logic [PC_W-1:0]  pred_fallthru,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [PC_W-1:0]  res_target,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             upd_valid,
  output logic             upd_taken,
  output logic             underflow_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);
  localparam int EW = 2*PC_W + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic [EW-1:0]   q_rdata;
  logic            q_full, q_empty;
  logic [AW:0]     q_cnt;
  logic            head_taken;
  logic [PC_W-1:0] head_target, head_fallthru;
  logic            pop, push, mispred;
  logic [PC_W-1:0] correct_pc;
  bru_state_e      state, state_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;

  // Entry layout matches bru_entry_t: {taken, target, fallthru}.
  assign {head_taken, head_target, head_fallthru} = q_rdata;

  assign pop        = res_valid & ~q_empty;
  assign mispred    = pop & ((res_taken != head_taken) |
                             (res_taken & (res_target != head_target)));
  assign correct_pc = res_taken ? res_target : head_fallthru;
  // A mispredict makes any same-cycle push wrong-path, so it is discarded.
  assign push       = pred_valid & pred_ready & ~mispred;

  bru_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (mispred),
    .wdata ({pred_taken, pred_target, pred_fallthru}),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      RUN: if (mispred) begin
        state_nxt = HOLD;
        hold_nxt  = HW'(HOLD_CYCLES);
      end
      HOLD: begin
        hold_nxt = hold_cnt - 1'b1;
        if (hold_cnt == HW'(1)) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Readiness comes from the current count, so a pop cannot open a slot in the same cycle.
  always_comb begin
    pred_ready = 1'b0;
    if (state == RUN) pred_ready = ~q_full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush         <= 1'b0;
      redirect_pc   <= '0;
      upd_valid     <= 1'b0;
      upd_taken     <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      flush     <= mispred;
      upd_valid <= pop;
      upd_taken <= pop & res_taken;
      if (mispred) redirect_pc <= correct_pc;
      if (res_valid && q_cnt == '0) underflow_err <= 1'b1;
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (pop)     branch_cnt  <= branch_cnt + CNT_W'(1);
      if (mispred) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end
`else
  assign branch_cnt  = '0;
  assign mispred_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, hand sequences and random traffic vs a queue model.
module tb_branch_resolve_unit;
  import bru_pkg::*;
  localparam int DEPTH = 4;
  localparam int HOLD  = 2;

  logic        clk = 1'b0, rst = 1'b1;
  logic        pred_valid = 0, pred_taken = 0, res_valid = 0, res_taken = 0;
  logic [31:0] pred_target = 0, pred_fallthru = 0, res_target = 0;
  logic        pred_ready, flush, upd_valid, upd_taken, underflow_err;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt, mispred_cnt;

  branch_resolve_unit #(.DEPTH(DEPTH), .PC_W(32), .HOLD_CYCLES(HOLD), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_fallthru(pred_fallthru), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .flush(flush), .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_taken(upd_taken),
    .underflow_err(underflow_err), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Reference model: queue of predictions plus remaining hold-off cycles.
  bru_entry_t  mq[$];
  int          m_hold;
  logic        m_flush, m_uv, m_ut, m_uf;
  logic [31:0] m_rpc;
  int          m_bc, m_mc;

  task automatic m_reset();
    mq.delete();
    m_hold = 0; m_flush = 0; m_uv = 0; m_ut = 0; m_uf = 0; m_rpc = 0; m_bc = 0; m_mc = 0;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "flush"}, flush, m_flush);
    chk({tag, "upd_valid"}, upd_valid, m_uv);
    chk({tag, "upd_taken"}, upd_taken, m_ut);
    chk({tag, "redirect_pc"}, redirect_pc, m_rpc);
    chk({tag, "underflow_err"}, underflow_err, m_uf);
`ifdef BRU_STATS_EN
    chk({tag, "branch_cnt"}, branch_cnt, 32'(m_bc & 16'hffff));
    chk({tag, "mispred_cnt"}, mispred_cnt, 32'(m_mc & 16'hffff));
`else
    chk({tag, "branch_cnt"}, branch_cnt, 0);
    chk({tag, "mispred_cnt"}, mispred_cnt, 0);
`endif
  endtask

  // One clock: drive inputs, check ready, advance model, check registered outputs.
  task automatic step(input logic pv, input logic pt, input logic [31:0] ptg, input logic [31:0] pft,
                      input logic rv, input logic rt, input logic [31:0] rtg, output logic rdy_s);
    logic rdy, pop, mis;
    bru_entry_t h;
    pred_valid = pv; pred_taken = pt; pred_target = ptg; pred_fallthru = pft;
    res_valid = rv; res_taken = rt; res_target = rtg;
    #1;
    rdy = (mq.size() < DEPTH) && (m_hold == 0);
    rdy_s = pred_ready;
    chk("pred_ready", pred_ready, rdy);
    pop = rv && mq.size() > 0;
    mis = 0;
    m_uv = pop; m_ut = pop & rt; m_flush = 0;
    if (rv && mq.size() == 0) m_uf = 1;
    if (pop) begin
      h = mq.pop_front();
      mis = (rt != h.taken) || (rt && rtg != h.target);
      m_bc++;
      if (mis) begin
        m_mc++; m_flush = 1; m_rpc = rt ? rtg : h.fallthru;
        mq.delete();
      end
    end
    if (mis) m_hold = HOLD;
    else if (m_hold > 0) m_hold--;
    if (pv && rdy && !mis) mq.push_back('{taken: pt, target: ptg, fallthru: pft});
    @(posedge clk);
    @(negedge clk);
    chk_outs("");
  endtask

  typedef struct {
    logic pv, pt; logic [31:0] ptg, pft;
    logic rv, rt; logic [31:0] rtg;
    logic e_rdy, e_fl; logic [31:0] e_rpc; logic e_uv, e_ut, e_uf;
  } vec_t;
  vec_t tv[16];

  initial begin
    logic r;
    // pv pt ptg pft rv rt rtg | rdy flush rpc uv ut uf
    tv[0]  = '{1,1,32'h100,32'h44, 0,0,32'h0,   1,0,32'h0,  0,0,0};
    tv[1]  = '{0,0,32'h0,  32'h0,  1,1,32'h100, 1,0,32'h0,  1,1,0};
    tv[2]  = '{1,0,32'h500,32'h48, 0,0,32'h0,   1,0,32'h0,  0,0,0};
    tv[3]  = '{0,0,32'h0,  32'h0,  1,1,32'h200, 1,1,32'h200,1,1,0};
    tv[4]  = '{0,0,32'h0,  32'h0,  0,0,32'h0,   0,0,32'h200,0,0,0};
    tv[5]  = '{1,1,32'h600,32'h60, 0,0,32'h0,   0,0,32'h200,0,0,0};
    tv[6]  = '{1,1,32'h300,32'h50, 0,0,32'h0,   1,0,32'h200,0,0,0};
    tv[7]  = '{0,0,32'h0,  32'h0,  1,1,32'h304, 1,1,32'h304,1,1,0};
    tv[8]  = '{0,0,32'h0,  32'h0,  0,0,32'h0,   0,0,32'h304,0,0,0};
    tv[9]  = '{0,0,32'h0,  32'h0,  0,0,32'h0,   0,0,32'h304,0,0,0};
    tv[10] = '{0,0,32'h0,  32'h0,  1,0,32'h0,   1,0,32'h304,0,0,1};
    tv[11] = '{1,0,32'h800,32'h84, 0,0,32'h0,   1,0,32'h304,0,0,1};
    tv[12] = '{1,1,32'h900,32'h90, 1,1,32'h880, 1,1,32'h880,1,1,1};
    tv[13] = '{0,0,32'h0,  32'h0,  0,0,32'h0,   0,0,32'h880,0,0,1};
    tv[14] = '{0,0,32'h0,  32'h0,  0,0,32'h0,   0,0,32'h880,0,0,1};
    tv[15] = '{0,0,32'h0,  32'h0,  1,0,32'h0,   1,0,32'h880,0,0,1};

    m_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset pred_ready", pred_ready, 1);
    chk_outs("reset ");

    foreach (tv[i]) begin
      step(tv[i].pv, tv[i].pt, tv[i].ptg, tv[i].pft, tv[i].rv, tv[i].rt, tv[i].rtg, r);
      chk($sformatf("tv%0d rdy", i), r, tv[i].e_rdy);
      chk($sformatf("tv%0d flush", i), flush, tv[i].e_fl);
      chk($sformatf("tv%0d rpc", i), redirect_pc, tv[i].e_rpc);
      chk($sformatf("tv%0d uv", i), upd_valid, tv[i].e_uv);
      chk($sformatf("tv%0d ut", i), upd_taken, tv[i].e_ut);
      chk($sformatf("tv%0d uf", i), underflow_err, tv[i].e_uf);
    end

    // Mispredict, then reset while flush/HOLD are active.
    step(1, 1, 32'h700, 32'h74, 0, 0, 0, r);
    step(0, 0, 0, 0, 1, 0, 0, r);
    chk("pre-rst flush", flush, 1);
    #2 rst = 1;
    #1;
    m_reset();
    chk("rst pred_ready", pred_ready, 1);
    chk_outs("rst ");
    @(negedge clk);
    rst = 0;

    // Fill to full, refused 5th push, four correct resolutions, then wrap pointers.
    for (int k = 0; k < 5; k++)
      step(1, k[0], 32'h1000 + 32'(k*16), 32'h2000 + 32'(k*4), 0, 0, 0, r);
    chk("full ready", pred_ready, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 1, k[0], 32'h1000 + 32'(k*16), r);
      chk("fill upd_valid", upd_valid, 1);
    end
    for (int k = 0; k < 6; k++)
      step(k < 3, 1, 32'h3000 + 32'(k), 32'h4000, k >= 3, 1, 32'h3000 + 32'(k-3), r);

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      logic rt; logic [31:0] rtg;
      rt  = 1'($urandom_range(1));
      rtg = 32'($urandom_range(255)) << 2;
      if (mq.size() > 0 && $urandom_range(3) != 0) begin
        rt = mq[0].taken;
        rtg = mq[0].target;
      end
      step($urandom_range(9) < 6, 1'($urandom_range(1)), 32'($urandom_range(255)) << 2,
           32'($urandom), $urandom_range(9) < 4, rt, rtg, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Consumer end of the branch-prediction path in the 5-stage MIPS pipeline. IF pushes each predicted branch (direction plus both candidate PCs) into a small in-order queue. When EX resolves the oldest branch, this block compares the actual outcome against the queued prediction, returns the outcome to the predictor, and on a mismatch issues a one-cycle pipeline flush with the corrected fetch PC. It then holds off new pushes while the squashed stages refill.

## Interface
- DEPTH, 4, max in-flight predicted branches (power of 2, ≥2)
- PC_W, 32, PC width
- HOLD_CYCLES, 2, cycles pushes are ignored after a flush (≥1)
- CNT_W, 16, statistics counter width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pred_valid  in  1  IF pushes one predicted branch
- pred_taken  in  1  predicted direction
- pred_target  in  PC_W  branch target PC
- pred_fallthru  in  PC_W  PC+4 of branch
- pred_ready  out  1  queue can accept a push (combinational, = not full and state RUN)
- res_valid  in  1  EX resolves oldest queued branch
- res_taken  in  1  actual direction
- res_target  in  PC_W  actual computed target
- flush  out  1  registered pulse: squash IF/ID/EX younger instructions
- redirect_pc  out  PC_W  corrected fetch PC, valid while flush=1
- upd_valid  out  1  registered pulse to predictor's branch input
- upd_taken  out  1  registered actual outcome to predictor's taken input
- underflow_err  out  1  sticky: res_valid arrived with empty queue
- branch_cnt  out  CNT_W  resolved branches
- mispred_cnt  out  CNT_W  mispredictions

## Operation
- Queue: DEPTH-entry FIFO of {pred_taken, pred_target, pred_fallthru}. Read/write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
- A push occurs iff pred_valid & pred_ready and no mispredict is detected in the same cycle. A push while full is dropped; pred_ready=0 signals this to IF.
- A pop occurs iff res_valid and the queue is non-empty. The head entry is compared against the resolution:
  - Mispredict = (res_taken != head.taken) | (res_taken & res_target != head.target).
  - Correct PC = res_taken ? res_target : head.fallthru.
- On a mispredict, the whole queue is cleared (remaining entries are wrong-path), and any simultaneous push is discarded.
- On res_valid with an empty queue: no pop, no update, no flush; underflow_err is set and stays set until rst.
- FSM states:
  - RUN → HOLD on a mispredict (load hold counter with HOLD_CYCLES).
  - HOLD decrements the counter and returns to RUN when it reaches 1.
  - In HOLD: pred_ready=0 and pushes are ignored. res_valid is still processed (no entries remain, so it follows the empty-queue rule).
- Full and pop in the same cycle: pred_ready is derived from the current count, so the push is still refused.

## Timing
- Reset values: flush=0, redirect_pc=0, upd_valid=0, upd_taken=0, underflow_err=0, counters=0, queue empty, state RUN. pred_ready=1 one cycle after rst deasserts.
- upd_valid/upd_taken: asserted in the cycle after each successful pop, for exactly 1 cycle.
- flush/redirect_pc: asserted in the cycle after a mispredicting pop, for 1 cycle. redirect_pc holds its last value otherwise.
- pred_ready: 0 from the cycle flush is high through HOLD_CYCLES cycles total; 1 in the following cycle.
- Back-to-back resolutions: one per cycle, each producing its own upd pulse.
- rst mid-flush or mid-HOLD aborts immediately to the reset values.
- Counters wrap modulo 2^CNT_W.

## Configuration
- BRU_STATS_EN defined: branch_cnt increments on every pop, and mispred_cnt increments on every mispredicting pop.
- BRU_STATS_EN undefined: the counter registers are not built, and branch_cnt/mispred_cnt are tied to 0.

## Structure
- bru_pkg: state enum (RUN, HOLD) and the queue entry struct {taken, target, fallthru}, parameterised via PC_W in the package.
- Sub-module bru_fifo: generic synchronous FIFO with push, pop, clear, full, empty and count. Clear has priority over push.

## Test plan
- Reset, push taken/target 0x100/fallthru 0x44, resolve taken 0x100 → upd_valid=1, upd_taken=1 next cycle, flush=0.
- Push not-taken (fallthru 0x48), resolve taken 0x200 → next cycle flush=1, redirect_pc=0x200, queue empty, pred_ready=0 for 2 cycles.
- Push taken target 0x300, resolve taken with target 0x304 → flush=1, redirect_pc=0x304.
- Fill 4 entries → pred_ready=0. A 5th push is dropped. 4 correct resolutions give 4 upd pulses, and the pointers wrap.
- res_valid on empty queue → underflow_err=1 (sticky), no upd_valid. Assert rst during HOLD → all outputs return to reset values.
- With BRU_STATS_EN: 3 pops, 1 mispredict → branch_cnt=3, mispred_cnt=1. Without the macro, both read 0.
